uart_byte_rx: RTL and testbench

Serial-to-byte front end of the solver board-load path. It oversamples the host UART line (8N1, LSB first), recovers each byte and presents it to the parser as `byte_in`/`valid_in`: an 8-bit value with a one-cycle strobe. It also flags framing errors and line-break conditions so a corrupt board download can be detected before the parser consumes it.

---
 rtl/uart_byte_rx.sv | 153 +++++++++++++++
 tb/tb_uart_byte_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver: oversamples the line, recovers LSB-first bytes and strobes them out,
// flagging framing errors and holding off on a line that stays low (break).
module uart_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       valid_out,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_param
            $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic [1:0]       sync_q;
    logic             rx_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchronizer; resets to the idle-high line level so reset release is not a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
            // two stages shift by one per clock instead of collapsing into a single flop.
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == LAST) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                // Returning to IDLE at mid-stop lets the next start edge be caught without a gap.
                if (cnt_q == LAST) begin
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_out  = byte_q;
    assign valid_out = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 8 clocks per bit: framing, back-to-back, glitch,
// framing error with break, reset mid-frame and bit-period jitter.
module tb_uart_byte_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] byte_out;
    logic       valid_out;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int overlap = 0;
    int last_e0 = 0;

    logic [7:0] vq_data[$];
    int         vq_cyc[$];
    int         fe_cyc[$];

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_out  (byte_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle; cyc then equals the edge that registered the strobe.
    always @(negedge clk) begin
        if (valid_out) begin
            vq_data.push_back(byte_out);
            vq_cyc.push_back(cyc);
        end
        if (frame_err) fe_cyc.push_back(cyc);
        if (valid_out && frame_err) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge. Even-numbered bits (start, d1, d3, ...) last len_even clocks,
    // odd-numbered ones len_odd. First capture edge E0 is the next posedge.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int len_even, input int len_odd);
        logic [9:0] frame;
        frame   = {stop_bit, b, 1'b0};
        last_e0 = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            rx = frame[j];
            repeat ((j % 2 == 0) ? len_even : len_odd) @(negedge clk);
        end
    endtask

    initial begin
        int base_v;
        int base_f;
        int e0_first;
        int glitch_e0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // 1. Single frame: strobe at E0+78
        base_v = vq_data.size();
        base_f = fe_cyc.size();
        send(8'hE0, 1'b1, CPB, CPB);
        idle(10);
        check("t1_count", vq_data.size() - base_v, 1);
        check("t1_byte", vq_data[base_v], 8'hE0);
        check("t1_latency", vq_cyc[base_v], last_e0 + 78);
        check("t1_no_ferr", fe_cyc.size() - base_f, 0);
        check("t1_busy_low", busy, 1'b0);
        check("t1_hold", byte_out, 8'hE0);

        // 2. Back-to-back board header, strobes 80 cycles apart
        base_v = vq_data.size();
        send(8'hE0, 1'b1, CPB, CPB);
        e0_first = last_e0;
        send(8'h04, 1'b1, CPB, CPB);
        send(8'hE0, 1'b1, CPB, CPB);
        send(8'h06, 1'b1, CPB, CPB);
        idle(20);
        check("t2_count", vq_data.size() - base_v, 4);
        check("t2_b0", vq_data[base_v],     8'hE0);
        check("t2_b1", vq_data[base_v + 1], 8'h04);
        check("t2_b2", vq_data[base_v + 2], 8'hE0);
        check("t2_b3", vq_data[base_v + 3], 8'h06);
        check("t2_c0", vq_cyc[base_v],     e0_first + 78);
        check("t2_c1", vq_cyc[base_v + 1], e0_first + 158);
        check("t2_c2", vq_cyc[base_v + 2], e0_first + 238);
        check("t2_c3", vq_cyc[base_v + 3], e0_first + 318);

        // 3. Two-cycle start glitch: START at E2, back to IDLE at E2+H+1 = E0+6
        base_v = vq_data.size();
        base_f = fe_cyc.size();
        rx = 1'b0;
        glitch_e0 = cyc + 1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("t3_cyc_e2", cyc, glitch_e0 + 2);
        check("t3_busy_e2", busy, 1'b1);
        repeat (3) @(negedge clk);
        check("t3_busy_e5", busy, 1'b1);
        @(negedge clk);
        check("t3_busy_e6", busy, 1'b0);
        idle(10);
        check("t3_no_valid", vq_data.size() - base_v, 0);
        check("t3_no_ferr", fe_cyc.size() - base_f, 0);
        send(8'hA5, 1'b1, CPB, CPB);
        idle(10);
        check("t3_count", vq_data.size() - base_v, 1);
        check("t3_byte", vq_data[base_v], 8'hA5);

        // 4. Framing error followed by a held-low line
        base_v = vq_data.size();
        base_f = fe_cyc.size();
        send(8'h3C, 1'b0, CPB, CPB);
        repeat (200) @(negedge clk);
        check("t4_ferr_count", fe_cyc.size() - base_f, 1);
        check("t4_ferr_cyc", fe_cyc[base_f], last_e0 + 78);
        check("t4_no_valid", vq_data.size() - base_v, 0);
        check("t4_byte_kept", byte_out, 8'hA5);
        check("t4_busy_break", busy, 1'b1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_busy_still", busy, 1'b1);
        @(negedge clk);
        check("t4_busy_exit", busy, 1'b0);
        idle(10);
        check("t4_no_phantom", vq_data.size() - base_v, 0);
        send(8'h01, 1'b1, CPB, CPB);
        idle(10);
        check("t4_count", vq_data.size() - base_v, 1);
        check("t4_byte", vq_data[base_v], 8'h01);
        check("t4_ferr_once", fe_cyc.size() - base_f, 1);

        // 5. Reset during data bit 4 of 0xFF
        base_v = vq_data.size();
        base_f = fe_cyc.size();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + 4) @(negedge clk);
        check("t5_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_byte_rst", byte_out, 8'h00);
        check("t5_valid_rst", valid_out, 1'b0);
        check("t5_ferr_rst", frame_err, 1'b0);
        check("t5_busy_rst", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(100);
        check("t5_no_valid", vq_data.size() - base_v, 0);
        check("t5_no_ferr", fe_cyc.size() - base_f, 0);
        send(8'h00, 1'b1, CPB, CPB);
        idle(10);
        check("t5_count", vq_data.size() - base_v, 1);
        check("t5_byte", vq_data[base_v], 8'h00);
        check("t5_latency", vq_cyc[base_v], last_e0 + 78);

        // 6. Bit-period jitter: alternating 9- and 7-cycle bits, both phases
        base_v = vq_data.size();
        send(8'h55, 1'b1, 9, 7);
        idle(10);
        send(8'hAA, 1'b1, 9, 7);
        idle(10);
        send(8'h55, 1'b1, 7, 9);
        idle(10);
        send(8'hAA, 1'b1, 7, 9);
        idle(10);
        check("t6_count", vq_data.size() - base_v, 4);
        check("t6_b0", vq_data[base_v],     8'h55);
        check("t6_b1", vq_data[base_v + 1], 8'hAA);
        check("t6_b2", vq_data[base_v + 2], 8'h55);
        check("t6_b3", vq_data[base_v + 3], 8'hAA);

        check("no_overlap", overlap, 0);
        check("total_ferr", fe_cyc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
